// File: rtl/id_pipe_stage.sv
// Instruction-decode pipeline stage for RV32I/RV64I. Decodes the fetched word, drives
// register-file read ports combinationally, and registers operands/control for execute.
module id_pipe_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            rs1_r_ena,
    output logic            rs2_r_ena,
    output logic [4:0]      rs1_r_addr,
    output logic [4:0]      rs2_r_addr,
    input  logic [XLEN-1:0] r_data1,
    input  logic [XLEN-1:0] r_data2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic            out_rd_w_ena,
    output logic [4:0]      out_rd_w_addr,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [9:0]      out_alu_info,
    output logic [7:0]      out_bj_info,
    output logic [XLEN-1:0] out_jmp_target,
    output logic            out_is_word,
    output logic            out_mem_to_reg,
    output logic            out_mem_w_ena,
    output logic [1:0]      out_mem_size,
    output logic            out_mem_unsigned,
    output logic            out_illegal
);

    localparam bit RV64 = (XLEN == 64);

    localparam logic [9:0] ALU_ADD  = 10'b00_0000_0001;
    localparam logic [9:0] ALU_SUB  = 10'b00_0000_0010;
    localparam logic [9:0] ALU_SLT  = 10'b00_0000_0100;
    localparam logic [9:0] ALU_SLTU = 10'b00_0000_1000;
    localparam logic [9:0] ALU_XOR  = 10'b00_0001_0000;
    localparam logic [9:0] ALU_OR   = 10'b00_0010_0000;
    localparam logic [9:0] ALU_AND  = 10'b00_0100_0000;
    localparam logic [9:0] ALU_SLL  = 10'b00_1000_0000;
    localparam logic [9:0] ALU_SRL  = 10'b01_0000_0000;
    localparam logic [9:0] ALU_SRA  = 10'b10_0000_0000;

    localparam logic [7:0] BJ_JALR = 8'h40;
    localparam logic [7:0] BJ_JAL  = 8'h80;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            rd_w_ena;
        logic [4:0]      rd_w_addr;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [9:0]      alu;
        logic [7:0]      bj;
        logic [XLEN-1:0] jmp_target;
        logic            is_word;
        logic            mem_to_reg;
        logic            mem_w_ena;
        logic [1:0]      mem_size;
        logic            mem_unsigned;
        logic            illegal;
    } dec_t;

    function automatic logic [9:0] alu_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_f3 = alt ? ALU_SUB : ALU_ADD;
            3'd1:    alu_f3 = ALU_SLL;
            3'd2:    alu_f3 = ALU_SLT;
            3'd3:    alu_f3 = ALU_SLTU;
            3'd4:    alu_f3 = ALU_XOR;
            3'd5:    alu_f3 = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    endfunction

    logic [6:0] opc;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, jalr_sum;

    assign opc = in_inst[6:0];
    assign rd  = in_inst[11:7];
    assign f3  = in_inst[14:12];
    assign rs1 = in_inst[19:15];
    assign rs2 = in_inst[24:20];
    assign f7  = in_inst[31:25];

    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
    assign jalr_sum = r_data1 + imm_i;

    dec_t dec_d, out_q;
    logic valid_q;
    logic ill, rs1_en, rs2_en, rd_en, hazard;

    always_comb begin
        dec_d  = '0;
        ill    = 1'b0;
        rs1_en = 1'b0;
        rs2_en = 1'b0;
        rd_en  = 1'b0;
        case (opc)
            7'h03: begin
                rs1_en = 1'b1; rd_en = 1'b1;
                dec_d.mem_to_reg   = 1'b1;
                dec_d.mem_size     = f3[1:0];
                dec_d.mem_unsigned = f3[2];
                dec_d.op1 = r_data1; dec_d.op2 = imm_i; dec_d.alu = ALU_ADD;
                ill = (f3 == 3'd7) || (!RV64 && (f3 == 3'd3 || f3 == 3'd6));
            end
            7'h0f: ill = (f3[2:1] != 2'b00);
            7'h13: begin
                rs1_en = 1'b1; rd_en = 1'b1;
                dec_d.op1 = r_data1; dec_d.op2 = imm_i;
                dec_d.alu = alu_f3(f3, (f3 == 3'd5) && in_inst[30]);
                // RV64 shifts take a 6-bit shamt, so inst[25] belongs to the amount
                if (f3 == 3'd1)
                    ill = RV64 ? (in_inst[31:26] != 6'd0) : (f7 != 7'd0);
                else if (f3 == 3'd5)
                    ill = RV64 ? (in_inst[31:26] != 6'b000000 && in_inst[31:26] != 6'b010000)
                               : (f7 != 7'b0000000 && f7 != 7'b0100000);
            end
            7'h17: begin
                rd_en = 1'b1;
                dec_d.op1 = in_pc; dec_d.op2 = imm_u; dec_d.alu = ALU_ADD;
            end
            7'h1b: begin
                rs1_en = 1'b1; rd_en = 1'b1; dec_d.is_word = 1'b1;
                dec_d.op1 = r_data1; dec_d.op2 = imm_i;
                dec_d.alu = alu_f3(f3, (f3 == 3'd5) && in_inst[30]);
                case (f3)
                    3'd0:    ill = 1'b0;
                    3'd1:    ill = (f7 != 7'd0);
                    3'd5:    ill = (f7 != 7'b0000000 && f7 != 7'b0100000);
                    default: ill = 1'b1;
                endcase
                if (!RV64) ill = 1'b1;
            end
            7'h23: begin
                rs1_en = 1'b1; rs2_en = 1'b1;
                dec_d.mem_w_ena = 1'b1; dec_d.mem_size = f3[1:0];
                dec_d.op1 = r_data1; dec_d.op2 = imm_s; dec_d.alu = ALU_ADD;
                ill = f3[2] || (!RV64 && f3 == 3'd3);
            end
            7'h33, 7'h3b: begin
                rs1_en = 1'b1; rs2_en = 1'b1; rd_en = 1'b1;
                dec_d.op1 = r_data1; dec_d.op2 = r_data2;
                dec_d.alu = alu_f3(f3, f7[5]);
                ill = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                if (opc == 7'h3b) begin
                    dec_d.is_word = 1'b1;
                    if (!RV64 || !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ill = 1'b1;
                end
            end
            7'h37: begin
                rd_en = 1'b1;
                dec_d.op2 = imm_u; dec_d.alu = ALU_ADD;
            end
            7'h63: begin
                rs1_en = 1'b1; rs2_en = 1'b1;
                dec_d.op1 = r_data1; dec_d.op2 = r_data2;
                dec_d.jmp_target = in_pc + imm_b;
                case (f3)
                    3'd0:    dec_d.bj = 8'h01;
                    3'd1:    dec_d.bj = 8'h02;
                    3'd4:    dec_d.bj = 8'h04;
                    3'd5:    dec_d.bj = 8'h08;
                    3'd6:    dec_d.bj = 8'h10;
                    3'd7:    dec_d.bj = 8'h20;
                    default: ill = 1'b1;
                endcase
            end
            7'h67: begin
                rs1_en = 1'b1; rd_en = 1'b1;
                dec_d.op1 = r_data1; dec_d.op2 = imm_i; dec_d.bj = BJ_JALR;
                dec_d.jmp_target = {jalr_sum[XLEN-1:1], 1'b0};
                ill = (f3 != 3'd0);
            end
            7'h6f: begin
                rd_en = 1'b1; dec_d.bj = BJ_JAL;
                dec_d.jmp_target = in_pc + imm_j;
            end
            7'h73: begin
                dec_d.op1 = r_data1;
                // funct3=0 covers ECALL/EBREAK/xRET/WFI, which never name registers
                if (f3 == 3'd0)      ill = (rd != 5'd0) || (rs1 != 5'd0);
                else if (f3 == 3'd4) ill = 1'b1;
                else begin
                    rd_en  = 1'b1;
                    rs1_en = ~f3[2];
                end
            end
            default: ill = 1'b1;
        endcase

        dec_d.pc        = in_pc;
        dec_d.rd_w_ena  = rd_en;
        dec_d.rd_w_addr = rd_en ? rd : 5'd0;
        dec_d.illegal   = ill;
        if (ill) begin
            rs1_en = 1'b0; rs2_en = 1'b0;
            dec_d.rd_w_ena = 1'b0; dec_d.rd_w_addr = 5'd0;
            dec_d.mem_to_reg = 1'b0; dec_d.mem_w_ena = 1'b0;
            dec_d.alu = '0; dec_d.bj = '0;
        end
    end

    assign rs1_r_ena  = rs1_en;
    assign rs2_r_ena  = rs2_en;
    assign rs1_r_addr = rs1_en ? rs1 : 5'd0;
    assign rs2_r_addr = rs2_en ? rs2 : 5'd0;

    assign hazard = valid_q && out_q.mem_to_reg && (out_q.rd_w_addr != 5'd0) &&
                    ((rs1_en && rs1 == out_q.rd_w_addr) || (rs2_en && rs2 == out_q.rd_w_addr));
    assign in_ready = ~hazard & (~valid_q | out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            out_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            out_q   <= dec_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid        = valid_q;
    assign out_pc           = out_q.pc;
    assign out_rd_w_ena     = out_q.rd_w_ena;
    assign out_rd_w_addr    = out_q.rd_w_addr;
    assign out_op1          = out_q.op1;
    assign out_op2          = out_q.op2;
    assign out_alu_info     = out_q.alu;
    assign out_bj_info      = out_q.bj;
    assign out_jmp_target   = out_q.jmp_target;
    assign out_is_word      = out_q.is_word;
    assign out_mem_to_reg   = out_q.mem_to_reg;
    assign out_mem_w_ena    = out_q.mem_w_ena;
    assign out_mem_size     = out_q.mem_size;
    assign out_mem_unsigned = out_q.mem_unsigned;
    assign out_illegal      = out_q.illegal;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed bench for id_pipe_stage: an RV64 instance for the main features and an RV32
// instance for the RV64-only / shift-amount legality boundaries.
module tb_id_pipe_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // RV64 instance
    logic        flush = 0, in_valid = 0, out_ready = 1;
    logic [31:0] in_inst = 0;
    logic [63:0] in_pc = 0, r_data1 = 0, r_data2 = 0;
    logic        in_ready, rs1_r_ena, rs2_r_ena, out_valid, out_rd_w_ena, out_is_word;
    logic        out_mem_to_reg, out_mem_w_ena, out_mem_unsigned, out_illegal;
    logic [4:0]  rs1_r_addr, rs2_r_addr, out_rd_w_addr;
    logic [63:0] out_pc, out_op1, out_op2, out_jmp_target;
    logic [9:0]  out_alu_info;
    logic [7:0]  out_bj_info;
    logic [1:0]  out_mem_size;

    // RV32 instance
    logic        flush32 = 0, in_valid32 = 0, out_ready32 = 1;
    logic [31:0] in_inst32 = 0, in_pc32 = 0, r_data1_32 = 0, r_data2_32 = 0;
    logic        in_ready32, rs1_r_ena32, rs2_r_ena32, out_valid32, out_rd_w_ena32, out_is_word32;
    logic        out_mem_to_reg32, out_mem_w_ena32, out_mem_unsigned32, out_illegal32;
    logic [4:0]  rs1_r_addr32, rs2_r_addr32, out_rd_w_addr32;
    logic [31:0] out_pc32, out_op1_32, out_op2_32, out_jmp_target32;
    logic [9:0]  out_alu_info32;
    logic [7:0]  out_bj_info32;
    logic [1:0]  out_mem_size32;

    id_pipe_stage #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .rs1_r_ena(rs1_r_ena), .rs2_r_ena(rs2_r_ena),
        .rs1_r_addr(rs1_r_addr), .rs2_r_addr(rs2_r_addr), .r_data1(r_data1), .r_data2(r_data2),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd_w_ena(out_rd_w_ena), .out_rd_w_addr(out_rd_w_addr), .out_op1(out_op1),
        .out_op2(out_op2), .out_alu_info(out_alu_info), .out_bj_info(out_bj_info),
        .out_jmp_target(out_jmp_target), .out_is_word(out_is_word),
        .out_mem_to_reg(out_mem_to_reg), .out_mem_w_ena(out_mem_w_ena),
        .out_mem_size(out_mem_size), .out_mem_unsigned(out_mem_unsigned),
        .out_illegal(out_illegal)
    );

    id_pipe_stage #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32), .in_valid(in_valid32), .in_ready(in_ready32),
        .in_inst(in_inst32), .in_pc(in_pc32), .rs1_r_ena(rs1_r_ena32), .rs2_r_ena(rs2_r_ena32),
        .rs1_r_addr(rs1_r_addr32), .rs2_r_addr(rs2_r_addr32), .r_data1(r_data1_32),
        .r_data2(r_data2_32), .out_valid(out_valid32), .out_ready(out_ready32),
        .out_pc(out_pc32), .out_rd_w_ena(out_rd_w_ena32), .out_rd_w_addr(out_rd_w_addr32),
        .out_op1(out_op1_32), .out_op2(out_op2_32), .out_alu_info(out_alu_info32),
        .out_bj_info(out_bj_info32), .out_jmp_target(out_jmp_target32),
        .out_is_word(out_is_word32), .out_mem_to_reg(out_mem_to_reg32),
        .out_mem_w_ena(out_mem_w_ena32), .out_mem_size(out_mem_size32),
        .out_mem_unsigned(out_mem_unsigned32), .out_illegal(out_illegal32)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if ({out_op1, out_op2, out_pc} !== 192'd0) begin errors++; $display("FAIL reset_data: got %h %h %h want 0", out_op1, out_op2, out_pc); end
        checks++; if ({out_alu_info, out_bj_info, out_illegal, out_rd_w_ena, out_mem_to_reg, out_mem_w_ena} !== 22'd0) begin errors++; $display("FAIL reset_ctrl: got %h %h %b want 0", out_alu_info, out_bj_info, out_illegal); end
        checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL reset_valid32: got %b want 0", out_valid32); end
        step();
        rst_n = 1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_addi();
        in_valid = 1; in_inst = 32'h0050_0093; in_pc = 64'h8000_0000; r_data1 = 0; out_ready = 1;
        #1;
        checks++; if ({rs1_r_ena, rs1_r_addr, rs2_r_ena, rs2_r_addr} !== {1'b1, 5'd0, 1'b0, 5'd0}) begin errors++; $display("FAIL addi_rports: got %b %d %b %d want 1 0 0 0", rs1_r_ena, rs1_r_addr, rs2_r_ena, rs2_r_addr); end
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        checks++; if (out_op1 !== 64'd0 || out_op2 !== 64'd5) begin errors++; $display("FAIL addi_ops: got %h %h want 0 5", out_op1, out_op2); end
        checks++; if (out_alu_info !== 10'h001 || out_rd_w_addr !== 5'd1 || out_rd_w_ena !== 1'b1) begin errors++; $display("FAIL addi_ctrl: got %h %d %b want 001 1 1", out_alu_info, out_rd_w_addr, out_rd_w_ena); end
        checks++; if (out_pc !== 64'h8000_0000 || out_illegal !== 1'b0) begin errors++; $display("FAIL addi_pc: got %h %b want 80000000 0", out_pc, out_illegal); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_load_use();
        in_valid = 1; in_inst = 32'h0001_3283; r_data1 = 64'h100; out_ready = 1;
        step();
        in_inst = 32'h0072_8333; r_data1 = 64'h11; r_data2 = 64'h22;
        #1;
        checks++; if (out_valid !== 1'b1 || out_mem_to_reg !== 1'b1 || out_mem_size !== 2'd3 || out_op1 !== 64'h100) begin errors++; $display("FAIL ld_out: got v%b m%b s%d op1 %h want 1 1 3 100", out_valid, out_mem_to_reg, out_mem_size, out_op1); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ld_hazard_ready: got %b want 0", in_ready); end
        checks++; if (rs1_r_addr !== 5'd5 || rs2_r_addr !== 5'd7) begin errors++; $display("FAIL add_rports: got %d %d want 5 7", rs1_r_addr, rs2_r_addr); end
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ld_bubble: got v%b r%b want 0 1", out_valid, in_ready); end
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || out_op1 !== 64'h11 || out_op2 !== 64'h22) begin errors++; $display("FAIL add_ops: got v%b %h %h want 1 11 22", out_valid, out_op1, out_op2); end
        checks++; if (out_alu_info !== 10'h001 || out_rd_w_addr !== 5'd6 || out_mem_to_reg !== 1'b0) begin errors++; $display("FAIL add_ctrl: got %h %d %b want 001 6 0", out_alu_info, out_rd_w_addr, out_mem_to_reg); end
        step();
    endtask

    task automatic test_store();
        in_valid = 1; in_inst = 32'hfe31_3c23; r_data1 = 64'h2000; r_data2 = 64'h77;
        #1;
        checks++; if (rs2_r_ena !== 1'b1 || rs2_r_addr !== 5'd3 || rs1_r_addr !== 5'd2) begin errors++; $display("FAIL sd_rports: got %b %d %d want 1 3 2", rs2_r_ena, rs2_r_addr, rs1_r_addr); end
        step();
        in_valid = 0;
        checks++; if (out_op2 !== 64'hFFFF_FFFF_FFFF_FFF8 || out_op1 !== 64'h2000) begin errors++; $display("FAIL sd_ops: got %h %h want 2000 fffffffffffffff8", out_op1, out_op2); end
        checks++; if (out_mem_w_ena !== 1'b1 || out_mem_size !== 2'd3 || out_rd_w_ena !== 1'b0 || out_mem_to_reg !== 1'b0) begin errors++; $display("FAIL sd_ctrl: got w%b s%d rd%b l%b want 1 3 0 0", out_mem_w_ena, out_mem_size, out_rd_w_ena, out_mem_to_reg); end
        step();
    endtask

    task automatic test_jumps();
        in_valid = 1; in_inst = 32'h0045_00e7; r_data1 = 64'h1003; in_pc = 64'h400;
        step();
        checks++; if (out_jmp_target !== 64'h1006 || out_bj_info !== 8'h40 || out_rd_w_addr !== 5'd1) begin errors++; $display("FAIL jalr: got %h %h %d want 1006 40 1", out_jmp_target, out_bj_info, out_rd_w_addr); end
        in_inst = 32'h0020_9863; in_pc = 64'h100;
        step();
        checks++; if (out_jmp_target !== 64'h110 || out_bj_info !== 8'h02 || out_rd_w_ena !== 1'b0) begin errors++; $display("FAIL bne: got %h %h %b want 110 02 0", out_jmp_target, out_bj_info, out_rd_w_ena); end
        in_inst = 32'h8000_01b7;
        step();
        checks++; if (out_op2 !== 64'hFFFF_FFFF_8000_0000 || out_op1 !== 64'd0 || out_rd_w_addr !== 5'd3) begin errors++; $display("FAIL lui: got %h %h %d want 0 ffffffff80000000 3", out_op1, out_op2, out_rd_w_addr); end
        in_inst = 32'h4020_e033;
        step();
        checks++; if (out_illegal !== 1'b1 || out_valid !== 1'b1 || out_alu_info !== 10'd0 || out_rd_w_ena !== 1'b0) begin errors++; $display("FAIL or_sub_illegal: got i%b v%b %h %b want 1 1 0 0", out_illegal, out_valid, out_alu_info, out_rd_w_ena); end
        in_inst = 32'h0200_9093;
        step();
        in_valid = 0;
        checks++; if (out_illegal !== 1'b0 || out_alu_info !== 10'h080) begin errors++; $display("FAIL slli32_rv64: got i%b %h want 0 080", out_illegal, out_alu_info); end
        step();
    endtask

    task automatic test_rv32();
        logic [31:0] vec [3];
        logic        exp_ill [3];
        vec[0] = 32'h0031_00bb; exp_ill[0] = 1'b1;
        vec[1] = 32'h0000_007f; exp_ill[1] = 1'b1;
        vec[2] = 32'h0200_9093; exp_ill[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid32 = 1; in_inst32 = vec[i];
            step();
            checks++; if (out_valid32 !== 1'b1 || out_illegal32 !== exp_ill[i]) begin errors++; $display("FAIL rv32_ill%0d: got v%b i%b want 1 %b", i, out_valid32, out_illegal32, exp_ill[i]); end
            checks++; if ({out_rd_w_ena32, out_mem_to_reg32, out_mem_w_ena32, out_alu_info32, out_bj_info32} !== 21'd0) begin errors++; $display("FAIL rv32_ena%0d: got %b %b %b %h %h want all 0", i, out_rd_w_ena32, out_mem_to_reg32, out_mem_w_ena32, out_alu_info32, out_bj_info32); end
        end
        in_inst32 = 32'h0050_0093; r_data1_32 = 0;
        step();
        in_valid32 = 0;
        checks++; if (out_illegal32 !== 1'b0 || out_op2_32 !== 32'd5 || out_alu_info32 !== 10'h001) begin errors++; $display("FAIL rv32_addi: got i%b %h %h want 0 5 001", out_illegal32, out_op2_32, out_alu_info32); end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1; in_valid = 1; r_data1 = 0;
        for (int i = 1; i <= 3; i++) begin
            in_inst = (32'(i) << 20) | (32'(i) << 7) | 32'h13;
            step();
            checks++; if (out_valid !== 1'b1 || out_op2 !== 64'(i) || out_rd_w_addr !== 5'(i)) begin errors++; $display("FAIL b2b_%0d: got v%b %h %d want 1 %0d %0d", i, out_valid, out_op2, out_rd_w_addr, i, i); end
        end
        in_valid = 0;
        step();
    endtask

    task automatic test_backpressure_flush();
        in_valid = 1; in_inst = 32'h0050_0093; out_ready = 0;
        step();
        in_inst = 32'h0070_0113;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_op2 !== 64'd5 || out_rd_w_addr !== 5'd1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: got v%b %h %d r%b want 1 5 1 0", i, out_valid, out_op2, out_rd_w_addr, in_ready); end
        end
        in_valid = 0; flush = 1;
        step();
        flush = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_flush: got v%b r%b want 0 1", out_valid, in_ready); end
        // flush wins over a handshake in the same cycle
        in_valid = 1; flush = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        step();
        flush = 0; in_valid = 0; out_ready = 1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        in_valid = 1; in_inst = 32'h0050_0093; out_ready = 0;
        step();
        in_valid = 0;
        #2;
        rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_op2 !== 64'd0) begin errors++; $display("FAIL async_reset: got v%b %h want 0 0", out_valid, out_op2); end
        step();
        rst_n = 1; out_ready = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_store();
        test_jumps();
        test_rv32();
        test_back_to_back();
        test_backpressure_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_pipe_stage.md
# id_pipe_stage

Registered, parametrised instruction-decode stage for the RV32I/RV64I core. It sits between the fetch stage and the execute stage. It takes one instruction per handshake and drives register-file read addresses combinationally. It latches decoded operands and control into an output pipeline register under a valid/ready handshake, with a load-use interlock, a pipeline flush and illegal-instruction detection.

## Interface
- XLEN, 64, datapath width; legal values 32 or 64. At 32, RV64-only encodings decode as illegal.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  drop the held instruction and any input this cycle (branch redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- rs1_r_ena / rs2_r_ena  out  1  combinational read enables, decoded from in_inst.
- rs1_r_addr / rs2_r_addr  out  5  read addresses; 0 when the matching enable is 0.
- r_data1 / r_data2  in  XLEN  register-file read data, same cycle.
- out_valid  out  1  the output register holds a valid instruction.
- out_ready  in  1  execute consumes the output this cycle.
- out_pc  out  XLEN  latched PC.
- out_rd_w_ena  out  1  writeback enable.
- out_rd_w_addr  out  5  writeback address.
- out_op1 / out_op2  out  XLEN  ALU operands.
- out_alu_info  out  10  one-hot: ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA.
- out_bj_info  out  8  one-hot: BEQ, BNE, BLT, BGE, BLTU, BGEU, JALR, JAL.
- out_jmp_target  out  XLEN  branch/jump target address.
- out_is_word  out  1  32-bit word op; result is sign-extended from bit 31.
- out_mem_to_reg / out_mem_w_ena  out  1  load / store.
- out_mem_size  out  2  0=B, 1=H, 2=W, 3=D.
- out_mem_unsigned  out  1  LBU/LHU/LWU.
- out_illegal  out  1  undecodable instruction.

## Operation
- Decode rules:
  - Opcodes 03, 0f, 13, 17, 1b, 23, 33, 37, 3b, 63, 67, 6f, 73 are decoded.
  - Any other opcode is illegal.
  - Undefined funct3/funct7 combinations are also illegal, e.g. SUB-class funct7 on OR, or funct3 2/3/7 under opcode 1b.
- Operand rules:
  - op1: rs1 data for load, I-arith, store, R, branch and system. PC for AUIPC. 0 for LUI.
  - op2, by instruction class:
    - I-type: immI sign-extended.
    - Store: immS sign-extended (inst[31:25], inst[11:7]).
    - R-type and branch: rs2 data.
    - AUIPC and LUI: {immU, 12'b0} sign-extended to XLEN.
    - System: 0.
- Jump target:
  - Branch: pc + immB.
  - JAL: pc + immJ.
  - JALR: (rs1 + immI) with bit 0 cleared.
  - All additions are modulo 2^XLEN.
- Shift amount is 6 bits at XLEN=64 and 5 bits otherwise. At XLEN=32, SLLI/SRLI/SRAI with inst[25]=1 are illegal.
- RV64-only encodings (LD, LWU, SD, opcodes 1b and 3b) are illegal at XLEN=32.
- On an illegal instruction:
  - out_illegal=1.
  - out_rd_w_ena, out_mem_to_reg, out_mem_w_ena, out_alu_info and out_bj_info are all 0.
  - The instruction still flows through the stage with out_valid=1.
- ECALL/EBREAK are legal and carry no ALU bit. CSR instructions write rd.
- Load-use hazard:
  - Condition: out_valid & out_mem_to_reg & out_rd_w_addr≠0, and the incoming instruction reads that register (rs1 or rs2, with its enable set).
  - While the hazard holds, in_ready=0.
- in_ready = ~hazard & (~out_valid | out_ready).
- Output register update, highest priority first:
  1. flush: out_valid←0.
  2. in_valid & in_ready: load the decoded fields, out_valid←1.
  3. out_ready: out_valid←0 (bubble).
  4. Otherwise: hold.
- While out_valid=1 and out_ready=0, every out_* field is stable.

## Timing
- Reset (rst_n=0, asynchronous):
  - out_valid=0.
  - All out_* data and control fields are 0, including out_illegal=0.
  - in_ready reads 1 once reset is released.
- Latency:
  - One cycle from an accepted input to out_valid.
  - Throughput is 1 instruction/cycle when out_ready=1 and there is no hazard.
- Load-use costs exactly one bubble cycle. The consumer is accepted in the cycle after the load leaves the stage.
- flush together with in_valid&in_ready: the input is discarded and out_valid is 0 next cycle. in_ready is still reported as computed; fetch treats the instruction as flushed.
- Read ports and rs*_r_ena are purely combinational from in_inst and carry no dependence on state.
- Reset asserted mid-stream clears out_valid immediately, without waiting for a clock edge.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) at pc 0x80000000:
  - One cycle later: out_valid=1, op1=0, op2=5, ALU ADD, rd_w_addr=1.
- LD x5,0(x2) followed by ADD x6,x5,x7 with out_ready=1:
  - in_ready=0 for one cycle and out_valid=0 for one cycle.
  - The ADD then appears with r_data1 as sampled.
- SD x3,-8(x2) (0xfe313c23):
  - op2 = 0xFFFFFFFFFFFFFFF8, mem_w_ena=1, mem_size=3, rd_w_ena=0.
- JALR x1,4(x10) with r_data1=0x1003:
  - out_jmp_target=0x1006, bj JALR, rd_w_addr=1.
- XLEN=32 build: ADDW (opcode 3b):
  - out_illegal=1 and all enables 0.
  - Same build, opcode 0x7f: also out_illegal=1 with all enables 0.
- Backpressure then flush:
  - Hold out_ready=0 for 3 cycles: output fields stable, in_ready=0.
  - Pulse flush: out_valid=0 next cycle, in_ready=1.
